// File: rtl/switch_arbiter.sv
// Per-output round-robin scheduler with packet lock for the 8-port crossbar.
// Drives the fabric's per-input grant vector; one owner per output.
module switch_arbiter #(
    parameter int N_PORTS = 8,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_PORTS-1:0] req,
    input  logic [N_PORTS-1:0] last,
    input  logic [ADDR_W-1:0]  addr [N_PORTS-1:0],
    output logic [N_PORTS-1:0] grant,
    output logic [N_PORTS-1:0] out_busy,
    output logic [N_PORTS-1:0] bad_addr
);
    localparam int PW = $clog2(N_PORTS);

    logic [PW-1:0]      owner_q [N_PORTS];
    logic [PW-1:0]      ptr_q   [N_PORTS];
    logic [PW-1:0]      owner_d [N_PORTS];
    logic [PW-1:0]      ptr_d   [N_PORTS];
    logic [N_PORTS-1:0] busy_d;
    logic [N_PORTS-1:0] grant_d;
    logic [N_PORTS-1:0] bad_d;
    logic [N_PORTS-1:0] rel;
    logic [N_PORTS-1:0] held;
    logic [N_PORTS-1:0] legal;
    logic               found;
    logic [PW-1:0]      idx;

    always_comb begin
        rel     = '0;
        held    = '0;
        legal   = '0;
        bad_d   = '0;
        busy_d  = '0;
        grant_d = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            legal[i] = 32'(addr[i]) < N_PORTS;
            bad_d[i] = req[i] & ~legal[i];
        end
        // An owner keeps its output unless it finishes or abandons the packet.
        for (int o = 0; o < N_PORTS; o++) begin
            rel[o] = out_busy[o] & (~req[owner_q[o]] |
                     (grant[owner_q[o]] & last[owner_q[o]]));
            if (out_busy[o] && !rel[o])
                held[owner_q[o]] = 1'b1;
        end
        for (int o = 0; o < N_PORTS; o++) begin
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            busy_d[o]  = out_busy[o] & ~rel[o];
            found      = 1'b0;
            if (!out_busy[o] || rel[o]) begin
                for (int k = 0; k < N_PORTS; k++) begin
                    idx = PW'((32'(ptr_q[o]) + k) % N_PORTS);
                    if (!found && req[idx] && legal[idx] && !held[idx] &&
                        32'(addr[idx]) == o) begin
                        found      = 1'b1;
                        owner_d[o] = idx;
                        ptr_d[o]   = PW'((32'(idx) + 1) % N_PORTS);
                        busy_d[o]  = 1'b1;
                    end
                end
            end
        end
        for (int o = 0; o < N_PORTS; o++)
            if (busy_d[o])
                grant_d[owner_d[o]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= '0;
            out_busy <= '0;
            bad_addr <= '0;
            for (int o = 0; o < N_PORTS; o++) begin
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end
        end else begin
            grant    <= grant_d;
            out_busy <= busy_d;
            bad_addr <= bad_d;
            for (int o = 0; o < N_PORTS; o++) begin
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end
endmodule

// File: tb/tb_switch_arbiter.sv
// Bench for switch_arbiter: directed scenarios plus random traffic
// checked against a per-output owner/pointer reference model.
module tb_switch_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] last;
    logic [3:0] addr [7:0];
    logic [7:0] grant;
    logic [7:0] out_busy;
    logic [7:0] bad_addr;

    int n_chk  = 0;
    int n_fail = 0;

    int         own [8];
    int         ptr [8];
    logic [7:0] mgrant;
    logic [7:0] mbusy;
    logic [7:0] mbad;

    switch_arbiter #(.N_PORTS(8), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .addr(addr),
        .grant(grant), .out_busy(out_busy), .bad_addr(bad_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < 8; o++) begin
            own[o] = -1;
            ptr[o] = 0;
        end
        mgrant = '0;
        mbusy  = '0;
        mbad   = '0;
    endtask

    // One clock: predict from current inputs, take the edge, compare.
    task automatic cycle();
        int nown [8];
        int nptr [8];
        bit rel  [8];
        bit hold [8];
        int i;
        for (int o = 0; o < 8; o++) hold[o] = 0;
        for (int o = 0; o < 8; o++) begin
            rel[o] = 0;
            if (own[o] >= 0)
                rel[o] = !req[own[o]] || (mgrant[own[o]] && last[own[o]]);
            if (own[o] >= 0 && !rel[o]) hold[own[o]] = 1;
        end
        for (int o = 0; o < 8; o++) begin
            nown[o] = rel[o] ? -1 : own[o];
            nptr[o] = ptr[o];
            if (own[o] < 0 || rel[o]) begin
                for (int k = 0; k < 8; k++) begin
                    i = (ptr[o] + k) % 8;
                    if (req[i] && int'(addr[i]) == o && !hold[i]) begin
                        nown[o] = i;
                        nptr[o] = (i + 1) % 8;
                        break;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        mgrant = '0;
        mbusy  = '0;
        for (int o = 0; o < 8; o++) begin
            own[o] = nown[o];
            ptr[o] = nptr[o];
            if (own[o] >= 0) begin
                mbusy[o]       = 1'b1;
                mgrant[own[o]] = 1'b1;
            end
        end
        for (int j = 0; j < 8; j++) mbad[j] = req[j] && addr[j] >= 4'd8;
        chk("grant", 32'(grant), 32'(mgrant));
        chk("out_busy", 32'(out_busy), 32'(mbusy));
        chk("bad_addr", 32'(bad_addr), 32'(mbad));
        for (int a = 0; a < 8; a++) begin
            if (grant[a]) begin
                chk("inv_legal", 32'(addr[a] < 4'd8), 32'd1);
                if (addr[a] < 4'd8)
                    chk("inv_busy", 32'(out_busy[addr[a][2:0]]), 32'd1);
                for (int b = a + 1; b < 8; b++)
                    if (grant[b])
                        chk("inv_unique", 32'(addr[a] != addr[b]), 32'd1);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(out_busy), 32'd0);
        chk("rst_bad", 32'(bad_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        req   = '0;
        last  = '0;
        for (int i = 0; i < 8; i++) addr[i] = '0;
        rst_n = 1'b1;
        #2;
        do_reset();

        req  = 8'hFF;
        last = 8'hFF;
        for (int i = 0; i < 8; i++) addr[i] = 4'd7;
        for (int k = 0; k < 9; k++) begin
            cycle();
            chk("t1_walk", 32'(grant), 32'(8'h01 << (k % 8)));
        end
        req = '0;
        cycle();

        last = '0;
        req  = 8'hFF;
        for (int i = 0; i < 8; i++) addr[i] = 4'(i);
        cycle();
        chk("t2_grant", 32'(grant), 32'hFF);
        chk("t2_busy", 32'(out_busy), 32'hFF);
        req = '0;
        cycle();

        do_reset();
        addr[2] = 4'd5;
        addr[6] = 4'd5;
        req     = 8'h44;
        last    = '0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t3_hold", 32'(grant), 32'h04);
            if (k == 3) last[2] = 1'b1;
        end
        cycle();
        chk("t3_next", 32'(grant), 32'h40);
        req     = 8'h42;
        last    = '0;
        addr[1] = 4'd5;
        cycle();
        chk("t6_lock", 32'(grant), 32'h40);
        req[6] = 1'b0;
        cycle();
        chk("t6_abort", 32'(grant), 32'h02);

        req     = 8'h09;
        addr[0] = 4'd0;
        addr[3] = 4'b1000;
        cycle();
        chk("t4_grant", 32'(grant), 32'h01);
        chk("t4_bad", 32'(bad_addr), 32'h08);
        cycle();
        chk("t4_bad_hold", 32'(bad_addr), 32'h08);
        req[3] = 1'b0;
        cycle();
        chk("t4_bad_clr", 32'(bad_addr), 32'h00);

        do_reset();
        for (int i = 0; i < 8; i++) addr[i] = 4'd2;
        req = 8'h20;
        cycle();
        chk("t5_pre", 32'(grant), 32'h20);
        req = 8'hFF;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_async_grant", 32'(grant), 32'd0);
        chk("t5_async_busy", 32'(out_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("t5_restart", 32'(grant), 32'h01);

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 8; i++) begin
                if (mgrant[i]) begin
                    req[i] = ($urandom % 16) != 0;
                end else begin
                    req[i]  = $urandom % 2;
                    addr[i] = 4'($urandom % 10);
                end
                last[i] = ($urandom % 3) == 0;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
